// File: rtl/lms_sample_scheduler.sv
// Sample scheduler for the 8-tap bit-serial LMS core: input FIFO, one start per
// sample, result hold with valid/ready, watchdog recovery of a hung core.
module lms_sample_scheduler #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 63,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [WIDTH-1:0] out_e,
    output logic             core_start,
    output logic [WIDTH-1:0] core_x,
    output logic [WIDTH-1:0] core_d,
    output logic             core_rst,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_y,
    input  logic [WIDTH-1:0] core_e,
    output logic             busy,
    output logic             err_timeout,
    input  logic             err_clear,
    output logic [CNT_W-1:0] sample_count
);

    localparam int AW  = $clog2(DEPTH);
    localparam int WDW = $clog2(TIMEOUT + 1);

    // state     | meaning
    // S_IDLE    | waiting for enable, a queued sample and a free result register
    // S_ISSUE   | start pulse to the core, watchdog cleared
    // S_WAIT    | core inputs held, waiting for done or watchdog expiry
    // S_CAPTURE | result just latched, returning to idle
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [2*WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;
    logic [WIDTH-1:0]   r_core_x;
    logic [WIDTH-1:0]   r_core_d;
    logic [WIDTH-1:0]   r_out_y;
    logic [WIDTH-1:0]   r_out_e;
    logic               r_out_valid;
    logic [WDW-1:0]     r_wd_cnt;
    logic               r_wd_pulse;
    logic               r_err;
    logic [CNT_W-1:0]   r_sample_count;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_issue;
    logic               w_done;
    logic               w_wd_fire;
    logic               w_accept;
    logic [2*WIDTH-1:0] w_head;

    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign in_ready  = !rst && !w_full;
    assign w_push    = in_valid && in_ready;
    assign w_issue   = (r_state == S_IDLE) && enable && !w_empty && !r_out_valid;
    assign w_done    = (r_state == S_WAIT) && core_done;
    // Fires on the cycle the counter would step to TIMEOUT; done on that cycle still wins.
    assign w_wd_fire = (r_state == S_WAIT) && !core_done && (r_wd_cnt == WDW'(TIMEOUT - 1));
    assign w_accept  = r_out_valid && out_ready;
    assign w_head    = r_mem[r_rd_ptr];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_issue) w_next = S_ISSUE;
            S_ISSUE:   w_next = S_WAIT;
            S_WAIT: begin
                if (w_done)         w_next = S_CAPTURE;
                else if (w_wd_fire) w_next = S_IDLE;
            end
            S_CAPTURE: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {in_x, in_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)  r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_issue) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_issue})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_core_x       <= '0;
            r_core_d       <= '0;
            r_out_y        <= '0;
            r_out_e        <= '0;
            r_out_valid    <= 1'b0;
            r_wd_cnt       <= '0;
            r_wd_pulse     <= 1'b0;
            r_err          <= 1'b0;
            r_sample_count <= '0;
        end else begin
            r_wd_pulse <= w_wd_fire;
            if (w_issue) begin
                r_core_x <= w_head[2*WIDTH-1:WIDTH];
                r_core_d <= w_head[WIDTH-1:0];
            end
            if (r_state == S_ISSUE)     r_wd_cnt <= '0;
            else if (r_state == S_WAIT) r_wd_cnt <= r_wd_cnt + WDW'(1);
            // Issue is blocked while a result is held, so done and accept never overlap.
            if (w_done) begin
                r_out_y     <= core_y;
                r_out_e     <= core_e;
                r_out_valid <= 1'b1;
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) r_sample_count <= r_sample_count + CNT_W'(1);
            if (w_wd_fire)      r_err <= 1'b1;
            else if (err_clear) r_err <= 1'b0;
        end
    end

    assign out_valid    = r_out_valid;
    assign out_y        = r_out_y;
    assign out_e        = r_out_e;
    assign core_start   = (r_state == S_ISSUE);
    assign core_x       = r_core_x;
    assign core_d       = r_core_d;
    assign core_rst     = rst || r_wd_pulse;
    assign busy         = (r_state != S_IDLE) || !w_empty;
    assign err_timeout  = r_err;
    assign sample_count = r_sample_count;

endmodule

// File: tb/tb_lms_sample_scheduler.sv
// Directed bench for lms_sample_scheduler with a behavioural 36-cycle core model.
module tb_lms_sample_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_x = '0;
    logic [15:0] in_d = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_y;
    logic [15:0] out_e;
    logic        core_start;
    logic [15:0] core_x;
    logic [15:0] core_d;
    logic        core_rst;
    logic        core_done = 1'b0;
    logic [15:0] core_y = '0;
    logic [15:0] core_e = '0;
    logic        busy;
    logic        err_timeout;
    logic        err_clear = 1'b0;
    logic [15:0] sample_count;

    lms_sample_scheduler #(.WIDTH(16), .DEPTH(4), .TIMEOUT(63), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_d(in_d),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_e(out_e),
        .core_start(core_start), .core_x(core_x), .core_d(core_d), .core_rst(core_rst),
        .core_done(core_done), .core_y(core_y), .core_e(core_e),
        .busy(busy), .err_timeout(err_timeout), .err_clear(err_clear),
        .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cnt = 0;
    int last_start = 0;
    int ov_cycles = 0;
    int m_cnt = 0;
    bit m_chk = 0;
    bit hang = 0;
    logic [15:0] m_x = '0;
    logic [15:0] m_d = '0;
    logic [15:0] got_y[$];
    logic [15:0] got_e[$];

    function automatic logic [15:0] exp_y(input logic [15:0] x);
        return x ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] exp_e(input logic [15:0] d);
        return d + 16'h0001;
    endfunction

    always @(posedge clk) cyc++;

    // Core model: done 36 cycles after the start cycle; also checks the inputs stay put.
    always @(negedge clk) begin
        core_done = 1'b0;
        if (rst) m_chk = 0;
        if (m_cnt > 0) begin
            if (m_chk) begin
                total++;
                if (core_x !== m_x || core_d !== m_d) begin
                    bad++;
                    $display("FAIL core_in_stable: x=%h d=%h expected x=%h d=%h", core_x, core_d, m_x, m_d);
                end
            end
            m_cnt--;
            if (m_cnt == 0) begin
                core_done = 1'b1;
                core_y = exp_y(m_x);
                core_e = exp_e(m_d);
            end
        end
        if (core_start) begin
            start_cnt++;
            last_start = cyc;
            m_x = core_x;
            m_d = core_d;
            m_chk = 1;
            if (!hang) m_cnt = 36;
        end
    end

    always @(negedge clk) begin
        #2;
        if (out_valid) ov_cycles++;
        if (out_valid && out_ready) begin
            got_y.push_back(out_y);
            got_e.push_back(out_e);
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        err_clear = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic push(input logic [15:0] x, input logic [15:0] d);
        bit ok = 0;
        in_x = x;
        in_d = d;
        in_valid = 1'b1;
        for (int n = 0; n < 300 && !ok; n++) begin
            if (in_ready) begin
                @(posedge clk);
                #1;
                ok = 1;
            end else begin
                tick;
            end
        end
        in_valid = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL push_timeout: x=%h never accepted within 300 cycles", x);
        end
    endtask

    task automatic wait_starts(input int n, input int max);
        int k = 0;
        while (start_cnt < n && k < max) begin
            tick;
            k++;
        end
        total++;
        if (start_cnt < n) begin
            bad++;
            $display("FAIL start_timeout: starts=%0d expected %0d", start_cnt, n);
        end
    endtask

    task automatic wait_results(input int n, input int max);
        int k = 0;
        while (got_y.size() < n && k < max) begin
            tick;
            k++;
        end
        total++;
        if (got_y.size() < n) begin
            bad++;
            $display("FAIL result_timeout: results=%0d expected %0d", got_y.size(), n);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        total++;
        if (in_ready !== 1'b0 || core_rst !== 1'b1) begin
            bad++;
            $display("FAIL reset_ctrl: in_ready=%b core_rst=%b expected 0 1", in_ready, core_rst);
        end
        total++;
        if ({out_valid, core_start, busy, err_timeout} !== 4'b0 || sample_count !== 16'd0 ||
            out_y !== 16'd0 || out_e !== 16'd0 || core_x !== 16'd0 || core_d !== 16'd0) begin
            bad++;
            $display("FAIL reset_values: ov=%b st=%b busy=%b err=%b cnt=%0d y=%h e=%h x=%h d=%h expected all 0",
                     out_valid, core_start, busy, err_timeout, sample_count, out_y, out_e, core_x, core_d);
        end
        rst = 1'b0;
        tick;
        total++;
        if (in_ready !== 1'b1 || core_rst !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL post_reset: in_ready=%b core_rst=%b busy=%b expected 1 0 0", in_ready, core_rst, busy);
        end
    endtask

    task automatic test_single;
        int s0, ss;
        int k = 0;
        do_reset;
        out_ready = 1'b1;
        s0 = start_cnt;
        push(16'h0100, 16'h0080);
        wait_starts(s0 + 1, 10);
        ss = last_start;
        total++;
        if (core_x !== 16'h0100 || core_d !== 16'h0080) begin
            bad++;
            $display("FAIL single_core_in: x=%h d=%h expected 0100 0080", core_x, core_d);
        end
        while (!out_valid && k < 60) begin
            tick;
            k++;
        end
        total++;
        if (cyc !== ss + 37) begin
            bad++;
            $display("FAIL single_latency: out_valid at cycle %0d expected %0d", cyc, ss + 37);
        end
        total++;
        if (out_y !== 16'h5B5A || out_e !== 16'h0081) begin
            bad++;
            $display("FAIL single_data: y=%h e=%h expected 5b5a 0081", out_y, out_e);
        end
        tick;
        total++;
        if (out_valid !== 1'b0 || sample_count !== 16'd1 || start_cnt !== s0 + 1) begin
            bad++;
            $display("FAIL single_done: ov=%b cnt=%0d starts=%0d expected 0 1 %0d",
                     out_valid, sample_count, start_cnt, s0 + 1);
        end
    endtask

    task automatic test_burst;
        logic [15:0] bx[6];
        logic [15:0] bd[6];
        int rb;
        do_reset;
        out_ready = 1'b1;
        rb = got_y.size();
        for (int i = 0; i < 6; i++) begin
            bx[i] = 16'h1000 * 16'(i + 1) + 16'h0011;
            bd[i] = 16'h8000 - 16'h0123 * 16'(i + 1);
        end
        for (int i = 0; i < 5; i++) push(bx[i], bd[i]);
        tick;
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL burst_full: in_ready=%b busy=%b expected 0 1", in_ready, busy);
        end
        push(bx[5], bd[5]);
        wait_results(rb + 6, 400);
        for (int i = 0; i < 6; i++) begin
            if (got_y.size() > rb + i) begin
                total++;
                if (got_y[rb+i] !== exp_y(bx[i]) || got_e[rb+i] !== exp_e(bd[i])) begin
                    bad++;
                    $display("FAIL burst_order[%0d]: y=%h e=%h expected %h %h",
                             i, got_y[rb+i], got_e[rb+i], exp_y(bx[i]), exp_e(bd[i]));
                end
            end
        end
        tick;
        total++;
        if (sample_count !== 16'd6) begin
            bad++;
            $display("FAIL burst_count: sample_count=%0d expected 6", sample_count);
        end
    endtask

    task automatic test_backpressure;
        int rb, s0, ta;
        int hold_bad = 0;
        int k = 0;
        do_reset;
        out_ready = 1'b0;
        rb = got_y.size();
        s0 = start_cnt;
        push(16'h7FFF, 16'h8001);
        push(16'hC3C3, 16'h0F0F);
        while (!out_valid && k < 60) begin
            tick;
            k++;
        end
        for (int i = 0; i < 100; i++) begin
            tick;
            if (!out_valid || out_y !== exp_y(16'h7FFF) || out_e !== exp_e(16'h8001) || start_cnt != s0 + 1)
                hold_bad++;
        end
        total++;
        if (hold_bad != 0) begin
            bad++;
            $display("FAIL bp_hold: %0d bad cycles (ov=%b y=%h starts=%0d) expected 0", hold_bad, out_valid, out_y, start_cnt);
        end
        out_ready = 1'b1;
        ta = cyc;
        wait_starts(s0 + 2, 10);
        total++;
        if (last_start !== ta + 2) begin
            bad++;
            $display("FAIL bp_reissue: second start at %0d expected %0d", last_start, ta + 2);
        end
        wait_results(rb + 2, 60);
        if (got_y.size() >= rb + 2) begin
            total++;
            if (got_y[rb] !== exp_y(16'h7FFF) || got_y[rb+1] !== exp_y(16'hC3C3) || got_e[rb+1] !== exp_e(16'h0F0F)) begin
                bad++;
                $display("FAIL bp_results: y0=%h y1=%h e1=%h expected %h %h %h", got_y[rb], got_y[rb+1], got_e[rb+1],
                         exp_y(16'h7FFF), exp_y(16'hC3C3), exp_e(16'h0F0F));
            end
        end
    endtask

    task automatic test_watchdog;
        int rb, s0, ss, ov0;
        int k = 0;
        do_reset;
        out_ready = 1'b1;
        hang = 1;
        rb = got_y.size();
        s0 = start_cnt;
        ov0 = ov_cycles;
        push(16'h2222, 16'h3333);
        push(16'h4444, 16'h5555);
        wait_starts(s0 + 1, 10);
        ss = last_start;
        while (!core_rst && k < 100) begin
            tick;
            k++;
        end
        total++;
        if (cyc !== ss + 64 || core_rst !== 1'b1) begin
            bad++;
            $display("FAIL wd_pulse_time: core_rst=%b at cycle %0d expected 1 at %0d", core_rst, cyc, ss + 64);
        end
        total++;
        if (err_timeout !== 1'b1) begin
            bad++;
            $display("FAIL wd_err_set: err_timeout=%b expected 1", err_timeout);
        end
        hang = 0;
        tick;
        total++;
        if (core_rst !== 1'b0) begin
            bad++;
            $display("FAIL wd_pulse_width: core_rst=%b expected 0", core_rst);
        end
        wait_starts(s0 + 2, 10);
        total++;
        if (last_start !== ss + 65) begin
            bad++;
            $display("FAIL wd_next_issue: start at %0d expected %0d", last_start, ss + 65);
        end
        wait_results(rb + 1, 60);
        total++;
        if (got_y.size() != rb + 1 || ov_cycles - ov0 != 1) begin
            bad++;
            $display("FAIL wd_dropped: results=%0d ov_cycles=%0d expected %0d 1", got_y.size() - rb, ov_cycles - ov0, 1);
        end else begin
            total++;
            if (got_y[rb] !== exp_y(16'h4444) || got_e[rb] !== exp_e(16'h5555)) begin
                bad++;
                $display("FAIL wd_second: y=%h e=%h expected %h %h", got_y[rb], got_e[rb], exp_y(16'h4444), exp_e(16'h5555));
            end
        end
        total++;
        if (err_timeout !== 1'b1) begin
            bad++;
            $display("FAIL wd_sticky: err_timeout=%b expected 1", err_timeout);
        end
        err_clear = 1'b1;
        tick;
        err_clear = 1'b0;
        total++;
        if (err_timeout !== 1'b0) begin
            bad++;
            $display("FAIL wd_clear: err_timeout=%b expected 0", err_timeout);
        end
    endtask

    task automatic test_enable;
        int rb, s0;
        int stall_bad = 0;
        do_reset;
        out_ready = 1'b1;
        enable = 1'b1;
        rb = got_y.size();
        s0 = start_cnt;
        push(16'hAAAA, 16'h1234);
        wait_starts(s0 + 1, 10);
        push(16'hBBBB, 16'h2345);
        push(16'hCCCC, 16'h3456);
        enable = 1'b0;
        wait_results(rb + 1, 60);
        if (got_y.size() > rb) begin
            total++;
            if (got_y[rb] !== exp_y(16'hAAAA)) begin
                bad++;
                $display("FAIL en_current: y=%h expected %h", got_y[rb], exp_y(16'hAAAA));
            end
        end
        for (int i = 0; i < 60; i++) begin
            tick;
            if (start_cnt != s0 + 1 || busy !== 1'b1) stall_bad++;
        end
        total++;
        if (stall_bad != 0) begin
            bad++;
            $display("FAIL en_stall: %0d bad cycles (starts=%0d busy=%b) expected 0", stall_bad, start_cnt, busy);
        end
        enable = 1'b1;
        wait_results(rb + 3, 150);
        if (got_y.size() >= rb + 3) begin
            total++;
            if (got_y[rb+1] !== exp_y(16'hBBBB) || got_y[rb+2] !== exp_y(16'hCCCC) || got_e[rb+2] !== exp_e(16'h3456)) begin
                bad++;
                $display("FAIL en_resume: y1=%h y2=%h e2=%h expected %h %h %h", got_y[rb+1], got_y[rb+2], got_e[rb+2],
                         exp_y(16'hBBBB), exp_y(16'hCCCC), exp_e(16'h3456));
            end
        end
        tick;
        total++;
        if (sample_count !== 16'd3) begin
            bad++;
            $display("FAIL en_count: sample_count=%0d expected 3", sample_count);
        end
    endtask

    task automatic test_rst_mid;
        int rb, s1, ov0;
        do_reset;
        out_ready = 1'b1;
        rb = got_y.size();
        push(16'h0F00, 16'h00F0);
        wait_results(rb + 1, 60);
        tick;
        total++;
        if (sample_count !== 16'd1) begin
            bad++;
            $display("FAIL rm_pre_count: sample_count=%0d expected 1", sample_count);
        end
        s1 = start_cnt;
        push(16'h1357, 16'h2468);
        wait_starts(s1 + 1, 10);
        push(16'h0001, 16'h0002);
        push(16'h0003, 16'h0004);
        push(16'h0005, 16'h0006);
        repeat (5) tick;
        ov0 = ov_cycles;
        rst = 1'b1;
        tick;
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || core_rst !== 1'b1 || sample_count !== 16'd0) begin
            bad++;
            $display("FAIL rm_reset: busy=%b ov=%b core_rst=%b cnt=%0d expected 0 0 1 0",
                     busy, out_valid, core_rst, sample_count);
        end
        rst = 1'b0;
        tick;
        total++;
        if (in_ready !== 1'b1 || core_rst !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rm_after: in_ready=%b core_rst=%b busy=%b expected 1 0 0", in_ready, core_rst, busy);
        end
        repeat (50) tick;
        total++;
        if (ov_cycles != ov0 || start_cnt != s1 + 1 || sample_count !== 16'd0) begin
            bad++;
            $display("FAIL rm_stray_done: ov_cycles=%0d starts=%0d cnt=%0d expected %0d %0d 0",
                     ov_cycles - ov0, start_cnt, sample_count, 0, s1 + 1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_single;
        test_burst;
        test_backpressure;
        test_watchdog;
        test_enable;
        test_rst_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lms_sample_scheduler.md
Name: lms_sample_scheduler

Overview:
- Sequences the 8-tap bit-serial LMS adaptive filter core.
- Accepts (x, d) sample pairs on a valid/ready stream and buffers them in a small FIFO.
- Issues one core start per sample, holds the core's inputs stable until the core reports done, then presents (y, e) on a valid/ready output stream.
- Includes a watchdog that resets a hung core, plus status: busy, sticky error, processed-sample count.

Parameters:
- WIDTH, 16, sample/weight width (signed two's complement).
- DEPTH, 4, input FIFO entries; power of two, at least 2.
- TIMEOUT, 63, maximum cycles in WAIT before the watchdog fires; must be at least 40.
- CNT_W, 16, width of the sample counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- enable  in  1  1 = may issue new samples to the core.
- in_valid  in  1  input sample valid.
- in_ready  out  1  input FIFO can accept a sample.
- in_x  in  WIDTH  signed reference sample.
- in_d  in  WIDTH  signed desired sample.
- out_valid  out  1  result register holds a result.
- out_ready  in  1  downstream accepts the result.
- out_y  out  WIDTH  filter output.
- out_e  out  WIDTH  error output.
- core_start  out  1  one-cycle start pulse to the core.
- core_x  out  WIDTH  x to the core.
- core_d  out  WIDTH  d to the core.
- core_rst  out  1  core reset.
- core_done  in  1  core done pulse (one cycle).
- core_y  in  WIDTH  core y_out.
- core_e  in  WIDTH  core e_out.
- busy  out  1  FSM not in IDLE, or FIFO non-empty.
- err_timeout  out  1  sticky watchdog flag.
- err_clear  in  1  clears err_timeout.
- sample_count  out  CNT_W  results delivered downstream.

Behaviour:
- Reset values: in_ready=0 during rst, then 1 (FIFO empty). The following are all 0: out_valid, out_y, out_e, core_start, core_x, core_d, busy, err_timeout, sample_count. FIFO is empty, FSM is in IDLE, watchdog counter is 0. core_rst=1 while rst is high.
- FIFO:
  - Push when in_valid && in_ready.
  - in_ready = !full; it is not relaxed by a same-cycle pop.
  - Pop only in IDLE->ISSUE.
  - Pointers wrap modulo DEPTH.
  - Order is strictly FIFO.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE.
- IDLE -> ISSUE when enable && FIFO non-empty && !out_valid.
  - Pops the head entry into core_x/core_d (registered).
- ISSUE:
  - core_start=1 for exactly this cycle.
  - Watchdog counter cleared.
  - Next state WAIT.
- WAIT:
  - core_x/core_d held constant, because the core samples d during its error phase.
  - Watchdog counter increments each cycle.
  - On core_done: latch core_y/core_e into out_y/out_e, go to CAPTURE.
  - When the counter reaches TIMEOUT without core_done:
    - err_timeout <= 1.
    - core_rst pulses high for one cycle. The core loses its adapted weights, which is accepted.
    - Sample is dropped; no result is produced.
    - Next state IDLE.
- CAPTURE:
  - out_valid <= 1.
  - Next state IDLE.
- Nominal core latency: done arrives 36 cycles after the start cycle. One sample therefore takes 39 cycles IDLE-to-IDLE, assuming an immediate downstream accept.
- Output handshake:
  - out_valid stays high and out_y/out_e stay stable until out_valid && out_ready.
  - On that accept, out_valid <= 0 and sample_count increments.
  - sample_count wraps at 2^CNT_W.
  - A new issue is blocked while out_valid=1, so back-pressure stalls at most one result.
- core_done outside WAIT is ignored.
- core_rst = rst OR the registered watchdog pulse.
- enable deasserted mid-sample: the current sample completes normally; no further issue until enable=1. The FIFO still accepts input.
- err_timeout: set by the watchdog, cleared by err_clear. If both happen in the same cycle, set wins.
- rst mid-operation:
  - All state returns to reset values.
  - FIFO contents and any pending result are discarded.
  - The core is reset through core_rst.
- Arithmetic: no arithmetic on data; y/e pass through bit-exact.

Test Plan:
1. Single sample: after rst, push x=0x0100, d=0x0080, out_ready=1 -> exactly one core_start pulse; core_x=0x0100 and core_d=0x0080 stable until done; core_done at start+36 gives out_valid one cycle after done; out_y/out_e equal the core values; sample_count=1.
2. Burst of 6 samples with DEPTH=4, core model busy -> in_ready drops after 4 buffered, with the FSM already holding 1 in flight; results emerge in push order; sample_count=6.
3. Back-pressure: out_ready=0 for 100 cycles with 2 samples queued -> out_valid held with stable data; no second core_start until the accept; then the second sample is issued.
4. Watchdog: core model never asserts done -> core_rst one-cycle pulse at start+1+TIMEOUT; err_timeout=1; no out_valid; next queued sample issued; err_clear drops the flag.
5. enable=0 asserted during WAIT -> current result delivered; no new core_start while enable=0, even with FIFO non-empty; resumes on enable=1.
6. rst asserted during WAIT with 3 samples queued -> next cycle: FIFO empty, out_valid=0, core_rst=1, sample_count=0; a later core_done is ignored.
